// File: rtl/rv_isa_pkg.sv
// rv_isa_pkg
//   Shared RV32IM encoding constants for the instruction encoder.
//   - Major opcodes, funct3/funct7 values and the canonical NOP.
//   - err_code_e: 3-bit error code attached to every encoded word.
//   - fifo_entry_t: one buffered output word plus its error code.
package rv_isa_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_SR  = 3'b101;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // addi x0,x0,0
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    ERR_NONE   = 3'd0,
    ERR_OPCODE = 3'd1,
    ERR_FUNCT  = 3'd2,
    ERR_ALIGN  = 3'd3,
    ERR_RANGE  = 3'd4
  } err_code_e;

  typedef struct packed {
    logic [31:0] instr;
    err_code_e   code;
  } fifo_entry_t;

  // Loads: lb, lh, lw, lbu, lhu
  function automatic logic load_f3_ok(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// instr_pack
//   Purely combinational RV32IM field packer with legality checks.
//   Inputs : opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, shamt_i,
//            imm_i (21-bit two's complement byte immediate; U-type uses
//            imm_i[19:0] as instr[31:12]).
//   Outputs: instr_o (packed word, or NOP on any error),
//            err_code_o (highest-priority error, ERR_NONE if legal).
module instr_pack
  import rv_isa_pkg::*;
(
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [4:0]  shamt_i,
  input  logic [20:0] imm_i,
  output logic [31:0] instr_o,
  output err_code_e   err_code_o
);

  // Sign-extension checks: the bits above the field's sign bit must all
  // be copies of it.
  logic i_fits;
  logic b_fits;
  assign i_fits = (imm_i[20:11] == '0) || (imm_i[20:11] == '1);
  assign b_fits = (imm_i[20:12] == '0) || (imm_i[20:12] == '1);

  logic [31:0] word;
  logic        bad_op;
  logic        bad_funct;
  logic        misaligned;
  logic        out_of_range;

  always_comb begin
    word         = '0;
    bad_op       = 1'b0;
    bad_funct    = 1'b0;
    misaligned   = 1'b0;
    out_of_range = 1'b0;

    unique case (opcode_i)
      OPC_LUI, OPC_AUIPC: begin
        word = {imm_i[19:0], rd_i, opcode_i};
      end
      OPC_JAL: begin
        word       = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        misaligned = imm_i[0];
      end
      OPC_JALR: begin
        word         = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        bad_funct    = (funct3_i != F3_ADD);
        out_of_range = !i_fits;
      end
      OPC_LOAD: begin
        word         = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        bad_funct    = !load_f3_ok(funct3_i);
        out_of_range = !i_fits;
      end
      OPC_OP_IMM: begin
        // Shift-immediates take shamt/funct7 instead of the immediate, so
        // no immediate range check applies to them.
        if (funct3_i == F3_SLL) begin
          word      = {funct7_i, shamt_i, rs1_i, funct3_i, rd_i, opcode_i};
          bad_funct = (funct7_i != F7_BASE);
        end else if (funct3_i == F3_SR) begin
          word      = {funct7_i, shamt_i, rs1_i, funct3_i, rd_i, opcode_i};
          bad_funct = (funct7_i != F7_BASE) && (funct7_i != F7_ALT);
        end else begin
          word         = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
          out_of_range = !i_fits;
        end
      end
      OPC_BRANCH: begin
        word         = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                        imm_i[4:1], imm_i[11], opcode_i};
        bad_funct    = (funct3_i == F3_SW) || (funct3_i == F3_SLTU);
        misaligned   = imm_i[0];
        out_of_range = !b_fits;
      end
      OPC_STORE: begin
        word         = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        bad_funct    = (funct3_i > F3_SW);
        out_of_range = !i_fits;
      end
      OPC_OP: begin
        word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
        if (funct7_i == F7_ALT) begin
          bad_funct = (funct3_i != F3_ADD) && (funct3_i != F3_SR);
        end else begin
          bad_funct = (funct7_i != F7_BASE) && (funct7_i != F7_MULDIV);
        end
      end
      default: begin
        bad_op = 1'b1;
      end
    endcase
  end

  always_comb begin
    if (bad_op) begin
      err_code_o = ERR_OPCODE;
    end else if (bad_funct) begin
      err_code_o = ERR_FUNCT;
    end else if (misaligned) begin
      err_code_o = ERR_ALIGN;
    end else if (out_of_range) begin
      err_code_o = ERR_RANGE;
    end else begin
      err_code_o = ERR_NONE;
    end
    instr_o = (err_code_o == ERR_NONE) ? word : INSTR_NOP;
  end

endmodule

// File: rtl/instr_encode.sv
// instr_encode
//   RV32IM instruction encoder with a DEPTH-entry output FIFO.
//   Request side : in_valid/in_ready handshake carrying decoded fields.
//   Output side  : out_valid/out_ready handshake; out_instr, out_err and
//                  out_err_code show the FIFO head (0 while empty).
//   err_count    : saturating count of accepted illegal requests.
//   Reset        : rst_n, synchronous, active-low.
module instr_encode
  import rv_isa_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned ERRW  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [4:0]      in_rd,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [4:0]      in_shamt,
  input  logic [20:0]     in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic            out_err,
  output logic [2:0]      out_err_code,
  output logic [ERRW-1:0] err_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0] enc_instr;
  err_code_e   enc_code;

  instr_pack u_pack (
    .opcode_i   (in_opcode),
    .rd_i       (in_rd),
    .rs1_i      (in_rs1),
    .rs2_i      (in_rs2),
    .funct3_i   (in_funct3),
    .funct7_i   (in_funct7),
    .shamt_i    (in_shamt),
    .imm_i      (in_imm),
    .instr_o    (enc_instr),
    .err_code_o (enc_code)
  );

  fifo_entry_t     mem_q [DEPTH];
  logic [PW-1:0]   wptr_q;
  logic [PW-1:0]   rptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic [ERRW-1:0] err_count_q;
  logic [ERRW-1:0] err_count_d;

  logic push;
  logic pop;
  logic push_err;

  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign push_err  = push && (enc_code != ERR_NONE);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    err_count_d = err_count_q;
    if (push_err && (err_count_q != '1)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  // Storage carries no reset; emptiness is tracked solely by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= '{instr: enc_instr, code: enc_code};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      err_count_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      count_q     <= count_d;
      err_count_q <= err_count_d;
    end
  end

  always_comb begin
    out_instr    = '0;
    out_err      = 1'b0;
    out_err_code = '0;
    if (out_valid) begin
      out_instr    = mem_q[rptr_q].instr;
      out_err_code = mem_q[rptr_q].code;
      out_err      = (mem_q[rptr_q].code != ERR_NONE);
    end
  end

  assign err_count = err_count_q;

endmodule

// File: tb/tb_instr_encode.sv
module tb_instr_encode;

  localparam int unsigned ERRW = 2;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      in_opcode;
  logic [4:0]      in_rd;
  logic [4:0]      in_rs1;
  logic [4:0]      in_rs2;
  logic [2:0]      in_funct3;
  logic [6:0]      in_funct7;
  logic [4:0]      in_shamt;
  logic [20:0]     in_imm;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic            out_err;
  logic [2:0]      out_err_code;
  logic [ERRW-1:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  instr_encode #(.DEPTH(2), .ERRW(ERRW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_rd        (in_rd),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_funct3    (in_funct3),
    .in_funct7    (in_funct7),
    .in_shamt     (in_shamt),
    .in_imm       (in_imm),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_err      (out_err),
    .out_err_code (out_err_code),
    .err_count    (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  sh;
    logic [20:0] imm;
    logic [31:0] exp_instr;
    logic [2:0]  exp_code;
  } vec_t;

  // Drives request fields only; comparisons live in the scenario tasks.
  task automatic drive(input vec_t v);
    in_valid  = 1'b1;
    in_opcode = v.op;
    in_rd     = v.rd;
    in_rs1    = v.rs1;
    in_rs2    = v.rs2;
    in_funct3 = v.f3;
    in_funct7 = v.f7;
    in_shamt  = v.sh;
    in_imm    = v.imm;
  endtask

  function automatic vec_t addi(input logic [4:0] rd, input logic [20:0] imm,
                                input logic [31:0] exp);
    vec_t v;
    v = '{op: 7'b0010011, rd: rd, rs1: 5'd0, rs2: 5'd0, f3: 3'b000, f7: 7'd0,
          sh: 5'd0, imm: imm, exp_instr: exp, exp_code: 3'd0};
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    n_checks++; if (err_count !== '0) begin n_fail++; $display("FAIL reset_err_count got %0d want 0", err_count); end
    n_checks++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_out_instr got %h want 0", out_instr); end
    n_checks++; if (out_err_code !== 3'd0 || out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err got %0b/%0d want 0/0", out_err, out_err_code); end
    rst_n = 1'b1;
  endtask

  task automatic test_addi();
    out_ready = 1'b0;
    drive(addi(5'd1, 21'd5, 32'h00500093));
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_pre_valid got %0b want 0", out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid got %0b want 1", out_valid); end
    n_checks++; if (out_instr !== 32'h00500093) begin n_fail++; $display("FAIL addi_instr got %h want 00500093", out_instr); end
    n_checks++; if (out_err !== 1'b0 || out_err_code !== 3'd0) begin n_fail++; $display("FAIL addi_err got %0b/%0d want 0/0", out_err, out_err_code); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drained got %0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    vec_t v [7];
    v[0] = '{7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 5'd0, 21'h12345, 32'h123452B7, 3'd0};
    v[1] = '{7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 5'd0, 21'h1FFFF8, 32'hFE208CE3, 3'd0};
    v[2] = '{7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 5'd0, 21'd8, 32'h0020A423, 3'd0};
    v[3] = '{7'b0010011, 5'd3, 5'd3, 5'd0, 3'b101, 7'b0100000, 5'd4, 21'h1ABCD, 32'h4041D193, 3'd0};
    v[4] = '{7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'b0000001, 5'd0, 21'd0, 32'h022081B3, 3'd0};
    v[5] = '{7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 5'd0, 21'h800, 32'h001000EF, 3'd0};
    v[6] = addi(5'd1, 21'h1FF800, 32'h80000093);
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(v[i]);
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1 || out_instr !== v[i].exp_instr || out_err !== 1'b0) begin
        n_fail++; $display("FAIL b2b_%0d got v=%0b %h err=%0b want v=1 %h err=0", i, out_valid, out_instr, out_err, v[i].exp_instr);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained got %0b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(addi(5'd1, 21'd1, 32'h00100093));
    @(posedge clk); #1;
    drive(addi(5'd2, 21'd2, 32'h00200113));
    @(posedge clk); #1;
    drive(addi(5'd3, 21'd3, 32'h00300193));
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got %0b want 0", in_ready); end
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b0 || out_instr !== 32'h00100093) begin
      n_fail++; $display("FAIL bp_hold got ready=%0b %h want 0 00100093", in_ready, out_instr);
    end
    out_ready = 1'b1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_pop_ready got %0b want 0", in_ready); end
    @(posedge clk); #1;
    n_checks++; if (out_instr !== 32'h00200113 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_second got %h ready=%0b want 00200113 1", out_instr, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_instr !== 32'h00300193) begin
      n_fail++; $display("FAIL bp_third got v=%0b %h want 1 00300193", out_valid, out_instr);
    end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got %0b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_errors();
    vec_t v [8];
    logic [ERRW-1:0] exp_cnt [8];
    v[0] = '{7'b0001111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 5'd0, 21'd0, 32'h00000013, 3'd1};
    v[1] = addi(5'd1, 21'd2048, 32'h00000013);
    v[1].exp_code = 3'd4;
    v[2] = '{7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 5'd0, 21'd7, 32'h00000013, 3'd3};
    // legal even offset: not an error, counter unchanged
    v[3] = '{7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 5'd0, 21'd6, 32'h00208363, 3'd0};
    // bad funct3 outranks misalignment and range
    v[4] = '{7'b1100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 5'd0, 21'h0F001, 32'h00000013, 3'd2};
    v[5] = '{7'b0110011, 5'd1, 5'd1, 5'd2, 3'b001, 7'b0100000, 5'd0, 21'd0, 32'h00000013, 3'd2};
    v[6] = '{7'b0010011, 5'd1, 5'd1, 5'd0, 3'b001, 7'b0100000, 5'd3, 21'd0, 32'h00000013, 3'd2};
    v[7] = '{7'b0100011, 5'd0, 5'd1, 5'd2, 3'b011, 7'd0, 5'd0, 21'd0, 32'h00000013, 3'd2};
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3;
    exp_cnt[4] = 2'd3; exp_cnt[5] = 2'd3; exp_cnt[6] = 2'd3; exp_cnt[7] = 2'd3;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(v[i]);
      @(posedge clk); #1;
      n_checks++; if (out_instr !== v[i].exp_instr || out_err_code !== v[i].exp_code ||
                      out_err !== (v[i].exp_code != 3'd0)) begin
        n_fail++; $display("FAIL err_%0d got %h code=%0d err=%0b want %h code=%0d", i, out_instr, out_err_code, out_err, v[i].exp_instr, v[i].exp_code);
      end
      n_checks++; if (err_count !== exp_cnt[i]) begin
        n_fail++; $display("FAIL err_count_%0d got %0d want %0d", i, err_count, exp_cnt[i]);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(addi(5'd1, 21'd1, 32'h00100093));
    @(posedge clk); #1;
    drive(addi(5'd2, 21'd2, 32'h00200113));
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_full got %0b want 0", in_ready); end
    rst_n = 1'b0;
    out_ready = 1'b1;
    drive('{7'b0001111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 5'd0, 21'd0, 32'h0, 3'd1});
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_count !== '0) begin
      n_fail++; $display("FAIL mid_reset got v=%0b r=%0b cnt=%0d want 0 1 0", out_valid, in_ready, err_count);
    end
    drive(addi(5'd1, 21'd5, 32'h00500093));
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_instr !== 32'h00500093 || out_err !== 1'b0) begin
      n_fail++; $display("FAIL mid_after got v=%0b %h err=%0b want 1 00500093 0", out_valid, out_instr, out_err);
    end
  endtask

  initial begin
    in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_shamt = '0; in_imm = '0;
    test_reset();
    test_addi();
    test_back_to_back();
    test_backpressure();
    test_errors();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
